// File: rtl/pc_branch_sequencer_if.sv
// Control-flow bundle between the EX stage / hazard unit and the PC sequencer.
// The sequencer takes the slave modport; the EX-stage driver takes the master modport.
interface pc_branch_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             Start;
   logic             Stall;
   logic             EXValid;
   logic [1:0]       EXBranch;
   logic             EXZero;
   logic             EXHalt;
   logic [31:0]      BranchTarget;
   logic [31:0]      JumpTarget;
   logic [31:0]      PC;
   logic [31:0]      PCPlus4;
   logic [1:0]       PCSrc;
   logic             FlushIFID;
   logic             FlushIDEX;
   logic             Running;
   logic             Halted;
   logic [CNT_W-1:0] BranchCount;
   logic [CNT_W-1:0] TakenCount;

   modport master (
      output Start, Stall, EXValid, EXBranch, EXZero, EXHalt, BranchTarget, JumpTarget,
      input  PC, PCPlus4, PCSrc, FlushIFID, FlushIDEX, Running, Halted, BranchCount, TakenCount
   );

   modport slave (
      input  Start, Stall, EXValid, EXBranch, EXZero, EXHalt, BranchTarget, JumpTarget,
      output PC, PCPlus4, PCSrc, FlushIFID, FlushIDEX, Running, Halted, BranchCount, TakenCount
   );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: picks PC+4 / branch / jump / hold, resolves redirects at EX,
// sequences IDLE/RUN/HALT and keeps saturating branch statistics for the debug display.
module pc_branch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input logic                   Clk,
   input logic                   Rst,
   pc_branch_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [1:0] SRC_PC4  = 2'b00;
   localparam logic [1:0] SRC_BR   = 2'b01;
   localparam logic [1:0] SRC_JMP  = 2'b10;
   localparam logic [1:0] SRC_HOLD = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
   logic [CNT_W-1:0] takenCnt_q, takenCnt_d;
   logic [31:0]      pcPlus4;
   logic [1:0]       pcSrc;
   logic             flush;
   logic             isCond;
   logic             taken;

   assign pcPlus4 = pc_q + 32'd4;

   // Bubbles (EXValid low) must never redirect, count or halt.
   assign isCond = bus.EXValid & ((bus.EXBranch == 2'b01) | (bus.EXBranch == 2'b10));
   assign taken  = bus.EXValid & (((bus.EXBranch == 2'b01) &  bus.EXZero) |
                                  ((bus.EXBranch == 2'b10) & ~bus.EXZero) |
                                   (bus.EXBranch == 2'b11));

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pcSrc       = SRC_HOLD;
      flush       = 1'b0;
      branchCnt_d = branchCnt_q;
      takenCnt_d  = takenCnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.Start) state_d = RUN;
         end
         RUN: begin
            // A halting instruction squashes everything younger, then freezes the PC.
            if (bus.EXValid & bus.EXHalt) begin
               state_d = HALT;
               flush   = 1'b1;
            end else if (taken) begin
               flush = 1'b1;
               if (bus.EXBranch == 2'b11) begin
                  pcSrc = SRC_JMP;
                  pc_d  = {bus.JumpTarget[31:2], 2'b00};
               end else begin
                  pcSrc = SRC_BR;
                  pc_d  = {bus.BranchTarget[31:2], 2'b00};
               end
            end else if (!bus.Stall) begin
               pcSrc = SRC_PC4;
               pc_d  = {pcPlus4[31:2], 2'b00};
            end

            if (isCond && branchCnt_q != '1) branchCnt_d = branchCnt_q + CNT_ONE;
            if (isCond && taken && takenCnt_q != '1) takenCnt_d = takenCnt_q + CNT_ONE;
         end
         HALT: begin
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset is synchronous and overrides any redirect or stall in flight.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         branchCnt_q <= '0;
         takenCnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         branchCnt_q <= branchCnt_d;
         takenCnt_q  <= takenCnt_d;
      end
   end

   assign bus.PC          = pc_q;
   assign bus.PCPlus4     = pcPlus4;
   assign bus.PCSrc       = pcSrc;
   assign bus.FlushIFID   = flush;
   assign bus.FlushIDEX   = flush;
   assign bus.Running     = (state_q == RUN);
   assign bus.Halted      = (state_q == HALT);
   assign bus.BranchCount = branchCnt_q;
   assign bus.TakenCount  = takenCnt_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed bench for pc_branch_sequencer: expected next-PC values are queued when each
// step is driven and popped once the following rising edge has updated the PC.
module tb_pc_branch_sequencer;

   logic Clk;
   logic Rst;
   int   total;
   int   bad;

   typedef struct {
      string       tag;
      logic [31:0] pc;
   } exp_t;

   exp_t sbq[$];

   pc_branch_sequencer_if #(.CNT_W(16)) bus ();

   pc_branch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge so they are stable well before the next rising edge.
   task automatic applyStimulus(input logic rst, input logic start, input logic stall,
                                input logic valid, input logic [1:0] br, input logic zero,
                                input logic halt, input logic [31:0] bt, input logic [31:0] jt);
      @(negedge Clk);
      Rst              = rst;
      bus.Start        = start;
      bus.Stall        = stall;
      bus.EXValid      = valid;
      bus.EXBranch     = br;
      bus.EXZero       = zero;
      bus.EXHalt       = halt;
      bus.BranchTarget = bt;
      bus.JumpTarget   = jt;
   endtask

   task automatic cycle(input string tag, input logic [1:0] expSrc, input logic expFlush,
                        input logic [31:0] expPc);
      exp_t e;
      #1;
      checkOutput({tag, ".src"}, {30'd0, bus.PCSrc}, {30'd0, expSrc});
      checkOutput({tag, ".flushIFID"}, {31'd0, bus.FlushIFID}, {31'd0, expFlush});
      checkOutput({tag, ".flushIDEX"}, {31'd0, bus.FlushIDEX}, {31'd0, expFlush});
      sbq.push_back('{tag, expPc});
      @(posedge Clk);
      #1;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
         e = sbq.pop_front();
         checkOutput({e.tag, ".pc"}, bus.PC, e.pc);
      end
   endtask

   task automatic checkCounts(input string tag, input logic [15:0] b, input logic [15:0] t);
      checkOutput({tag, ".branchCnt"}, {16'd0, bus.BranchCount}, {16'd0, b});
      checkOutput({tag, ".takenCnt"}, {16'd0, bus.TakenCount}, {16'd0, t});
   endtask

   task automatic checkState(input string tag, input logic run, input logic hlt);
      checkOutput({tag, ".running"}, {31'd0, bus.Running}, {31'd0, run});
      checkOutput({tag, ".halted"}, {31'd0, bus.Halted}, {31'd0, hlt});
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset held for two edges, then idle outputs.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge Clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge Clk);
      #1;
      checkOutput("reset.pc", bus.PC, 32'h0);
      checkState("reset", 1'b0, 1'b0);
      checkCounts("reset", 16'd0, 16'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("idle.start", 2'b11, 1'b0, 32'h0);
      checkState("run", 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("seq4", 2'b00, 1'b0, 32'h4);
      cycle("seq8", 2'b00, 1'b0, 32'h8);
      cycle("seqC", 2'b00, 1'b0, 32'hC);
      cycle("seq10", 2'b00, 1'b0, 32'h10);

      // Taken beq, then jump back and repeat not-taken.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h40, 32'h0);
      cycle("beq.taken", 2'b01, 1'b1, 32'h40);
      checkCounts("beq.taken", 16'd1, 16'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h10);
      cycle("j.back", 2'b10, 1'b1, 32'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h40, 32'h0);
      cycle("beq.not", 2'b00, 1'b0, 32'h14);
      checkCounts("beq.not", 16'd2, 16'd1);

      // Stall holds; redirect overrides stall.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h20);
      cycle("j.20", 2'b10, 1'b1, 32'h20);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) cycle("stall", 2'b11, 1'b0, 32'h20);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h80);
      cycle("stall.j", 2'b10, 1'b1, 32'h80);

      // Halt squashes, then freezes against branches and Start.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h30);
      cycle("j.30", 2'b10, 1'b1, 32'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
      cycle("halt", 2'b11, 1'b1, 32'h30);
      checkState("halt", 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int i = 0; i < 10; i++) cycle("halt.frozen", 2'b11, 1'b0, 32'h30);
      checkCounts("halt.frozen", 16'd2, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge Clk);
      #1;
      checkOutput("halt.reset.pc", bus.PC, 32'h0);
      checkState("halt.reset", 1'b0, 1'b0);
      checkCounts("halt.reset", 16'd0, 16'd0);

      // Target alignment and PC wrap.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("restart", 2'b11, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h43, 32'h0);
      cycle("align", 2'b01, 1'b1, 32'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
      cycle("j.top", 2'b10, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap.pcplus4", bus.PCPlus4, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle("wrap", 2'b00, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 32'h100, 32'h200);
      cycle("bubble", 2'b00, 1'b0, 32'h4);
      checkCounts("bubble", 16'd1, 16'd1);

      // Drive the counters to saturation with taken bne events.
      for (int i = 0; i < 65534; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
         @(posedge Clk);
      end
      #1;
      checkCounts("sat", 16'hFFFF, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h100, 32'h0);
      cycle("sat.taken", 2'b01, 1'b1, 32'h100);
      checkCounts("sat.taken", 16'hFFFF, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 32'h200, 32'h0);
      cycle("sat.not", 2'b00, 1'b0, 32'h104);
      checkCounts("sat.not", 16'hFFFF, 16'hFFFF);

      // Reset in the same cycle a taken beq resolves.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h80, 32'h0);
      cycle("rst.redirect", 2'b01, 1'b1, 32'h0);
      checkState("rst.redirect", 1'b0, 1'b0);
      checkCounts("rst.redirect", 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h80, 32'h0);
      cycle("rst.idle", 2'b11, 1'b0, 32'h0);
      checkCounts("rst.idle", 16'd0, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
